popcount_stream: RTL and testbench
==================================

POPCOUNT_STREAM -- requirements
Module: popcount_stream

Interface
REQ-001 SHALL have parameter W, default 32, meaning input word width; legal values are powers of two from 8 to 256.
REQ-002 SHALL have parameter ACC_W, default 16, meaning the count/accumulator width; it SHALL be at least clog2(W+1).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: input word valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-007 SHALL have port in_data, input, W bits: word whose set bits are counted.
REQ-008 SHALL have port in_last, input, 1 bit: final word of a frame.
REQ-009 SHALL have port mode, input, 1 bit: 0 = per-word count, 1 = frame accumulate.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_count, output, ACC_W bits: the count result.
REQ-013 SHALL have port out_last, output, 1 bit: result corresponds to a word carrying in_last.
REQ-014 SHALL have port out_sat, output, 1 bit: the accumulated count saturated.

Function
REQ-015 A word SHALL transfer on any cycle where in_valid=1 and in_ready=1; a result SHALL transfer on any cycle where out_valid=1 and out_ready=1.
REQ-016 Pipeline: stage 1 SHALL register per-byte popcounts (W/8 values of 4 bits each); stage 2 SHALL register their sum, zero-extended to ACC_W, plus accumulation; the output register SHALL be stage 2.
REQ-017 Latency: a result SHALL appear at out_valid exactly 2 cycles after the accepting transfer when there is no backpressure; throughput SHALL be 1 word per cycle.
REQ-018 Advance condition: adv = !out_valid | out_ready; in_ready SHALL equal adv (combinational); both stages SHALL hold their contents when adv=0.
REQ-019 in_ready SHALL NOT depend on in_valid.
REQ-020 Output data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Mode 0: every accepted word SHALL produce one result, out_count = number of ones in in_data, out_sat=0, and out_last = in_last of that word.
REQ-022 Mode 1: words SHALL add into a running accumulator; only the word with in_last=1 SHALL produce a result, with out_count = frame total and out_last=1; non-last words SHALL produce no out_valid.
REQ-023 Mode SHALL be sampled on the first word of each frame (the first word after reset or after an in_last word) and held to frame end; mode changes mid-frame SHALL be ignored.
REQ-024 Mode 1 saturation: if the accumulator would exceed 2^ACC_W-1, it SHALL clamp to 2^ACC_W-1 and set a sticky flag; out_sat on the frame result SHALL equal that flag; the accumulator and flag SHALL clear after the frame result is produced.
REQ-025 A single-word frame (in_last on the first word) in mode 1 SHALL yield the same count as mode 0 with out_last=1.
REQ-026 The accumulator SHALL update only on stage-2 advance, so it never double-counts a word during a stall.

Reset
REQ-027 When rst=1 at a clock edge, all stage valids, the accumulator, the saturation flag and the frame-start state SHALL clear; the next word SHALL be treated as a frame start.
REQ-028 During and after reset: out_valid=0, out_count=0, out_last=0, out_sat=0; in_ready=1.
REQ-029 Reset mid-frame or mid-stall SHALL discard all in-flight words and the partial accumulation with no output.

Verification (W=32, ACC_W=16)
REQ-030 Mode 0, out_ready=1; words 0x00000000, 0xFFFFFFFF, 0x80000001, and 0xA5A5A5A5 back-to-back -> counts 0, 32, 2, 16 on consecutive cycles, each appearing 2 cycles after its input.
REQ-031 Mode 1; frame 0xFFFFFFFF, 0x0000000F, then 0x00000001 with in_last=1 -> single result with out_count=37, out_last=1, out_sat=0; no other out_valid.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles with 3 words offered -> in_ready=0 while out_valid=1; out_count stable; after release, all results delivered in order with none lost or duplicated.
REQ-033 ACC_W=6, mode 1; three words of 0xFFFFFFFF, the last with in_last=1 -> out_count=63, out_sat=1; the next frame, a single 0x1 word -> count 1, out_sat=0.
REQ-034 Mode toggled from 1 to 0 mid-frame -> frame still accumulates; assert rst mid-frame -> no output, and the next mode-0 word counts correctly.

Source files
------------

// File: rtl/popcount_stream.sv
// Streaming popcount: two-stage pipeline counting set bits per word, or accumulating a
// saturating per-frame total, with valid/ready handshakes on both sides.
module popcount_stream #(
  parameter int unsigned W     = 32,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_last,
  output logic             out_sat
);

  localparam int unsigned NumBytes = W / 8;
  localparam int unsigned SumW     = $clog2(W + 1);

  logic adv;
  logic accept;
  logic eff_mode;

  // Frame tracking: mode is latched on the first word of a frame.
  logic in_frame_q;
  logic frame_mode_q;

  logic [NumBytes-1:0][3:0] byte_cnt_d;
  logic [NumBytes-1:0][3:0] s1_cnt_q;
  logic                     s1_valid_q;
  logic                     s1_last_q;
  logic                     s1_mode_q;

  logic [SumW-1:0]  word_sum;
  logic [ACC_W-1:0] word_sum_ext;
  logic [ACC_W:0]   acc_sum;
  logic             acc_ovf;
  logic [ACC_W-1:0] acc_clamped;

  logic [ACC_W-1:0] acc_q;
  logic             sat_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_count_q;
  logic             out_last_q;
  logic             out_sat_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign eff_mode = in_frame_q ? frame_mode_q : mode;

  always_comb begin
    byte_cnt_d = '0;
    for (int b = 0; b < NumBytes; b++) begin
      for (int i = 0; i < 8; i++) begin
        byte_cnt_d[b] = byte_cnt_d[b] + {3'b000, in_data[8*b+i]};
      end
    end
  end

  always_comb begin
    word_sum = '0;
    for (int b = 0; b < NumBytes; b++) begin
      word_sum = word_sum + SumW'(s1_cnt_q[b]);
    end
    word_sum_ext = ACC_W'(word_sum);
    acc_sum      = {1'b0, acc_q} + {1'b0, word_sum_ext};
    acc_ovf      = acc_sum[ACC_W];
    acc_clamped  = acc_ovf ? '1 : acc_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame_q   <= 1'b0;
      frame_mode_q <= 1'b0;
      s1_cnt_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_mode_q    <= 1'b0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
      out_sat_q    <= 1'b0;
    end else begin
      if (accept) begin
        in_frame_q   <= !in_last;
        frame_mode_q <= eff_mode;
      end
      if (adv) begin
        s1_valid_q  <= in_valid;
        s1_cnt_q    <= byte_cnt_d;
        s1_last_q   <= in_last;
        s1_mode_q   <= eff_mode;
        out_valid_q <= 1'b0;
        if (s1_valid_q) begin
          if (!s1_mode_q) begin
            out_valid_q <= 1'b1;
            out_count_q <= word_sum_ext;
            out_last_q  <= s1_last_q;
            out_sat_q   <= 1'b0;
          end else if (s1_last_q) begin
            out_valid_q <= 1'b1;
            out_count_q <= acc_clamped;
            out_last_q  <= 1'b1;
            out_sat_q   <= sat_q || acc_ovf;
            acc_q       <= '0;
            sat_q       <= 1'b0;
          end else begin
            acc_q <= acc_clamped;
            sat_q <= sat_q || acc_ovf;
          end
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_popcount_stream.sv
// Randomized and directed bench: two DUTs (ACC_W=16 and ACC_W=6) share stimulus and are
// compared against a frame-level reference model.
module tb_popcount_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        mode = 1'b0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_out_last, a_out_sat;
  logic [15:0] a_out_count;
  logic        b_in_ready, b_out_valid, b_out_last, b_out_sat;
  logic [5:0]  b_out_count;

  always #5 clk = ~clk;

  popcount_stream #(.W(32), .ACC_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_last(in_last), .mode(mode), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_count(a_out_count), .out_last(a_out_last), .out_sat(a_out_sat)
  );

  popcount_stream #(.W(32), .ACC_W(6)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_last(in_last), .mode(mode), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_count(b_out_count), .out_last(b_out_last), .out_sat(b_out_sat)
  );

  typedef struct {
    int unsigned cnt_a;
    bit          sat_a;
    int unsigned cnt_b;
    bit          sat_b;
    bit          last;
    int          cyc;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          chk_lat = 0;
  bit          acc_flag = 0;
  bit          m_in_frame = 0;
  bit          m_mode = 0;
  int unsigned m_acc = 0;
  bit          hold = 0;
  logic [15:0] h_cnt;
  logic        h_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called once per cycle at the falling edge, where inputs and outputs are settled.
  task automatic monitor();
    res_t        e;
    res_t        g;
    int unsigned pc;
    bit          m;
    cyc++;
    acc_flag = 0;
    if (rst) begin
      exp_q.delete();
      m_in_frame = 0;
      m_acc = 0;
      hold = 0;
      return;
    end
    check("in_ready_rule", a_in_ready, !a_out_valid || out_ready);
    check("b_in_ready", b_in_ready, a_in_ready);
    check("b_out_valid", b_out_valid, a_out_valid);
    if (hold && a_out_valid) begin
      check("stable_count", a_out_count, h_cnt);
      check("stable_last", a_out_last, h_last);
    end
    hold   = a_out_valid && !out_ready;
    h_cnt  = a_out_count;
    h_last = a_out_last;
    if (a_out_valid && out_ready) begin
      g.cnt_a = a_out_count; g.sat_a = a_out_sat;
      g.cnt_b = b_out_count; g.sat_b = b_out_sat;
      g.last  = a_out_last;  g.cyc   = cyc;
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("cnt_a", a_out_count, e.cnt_a);
        check("sat_a", a_out_sat, e.sat_a);
        check("cnt_b", b_out_count, e.cnt_b);
        check("sat_b", b_out_sat, e.sat_b);
        check("last_a", a_out_last, e.last);
        check("last_b", b_out_last, e.last);
        if (chk_lat) check("latency", cyc - e.cyc, 2);
      end
    end
    if (in_valid && a_in_ready) begin
      acc_flag = 1;
      pc = $countones(in_data);
      m  = m_in_frame ? m_mode : mode;
      if (!m_in_frame) m_mode = mode;
      e.cyc  = cyc;
      e.last = in_last;
      if (!m) begin
        e.cnt_a = pc; e.sat_a = 0; e.cnt_b = pc; e.sat_b = 0;
        exp_q.push_back(e);
      end else begin
        m_acc += pc;
        if (in_last) begin
          e.cnt_a = (m_acc > 65535) ? 65535 : m_acc;
          e.sat_a = (m_acc > 65535);
          e.cnt_b = (m_acc > 63) ? 63 : m_acc;
          e.sat_b = (m_acc > 63);
          exp_q.push_back(e);
          m_acc = 0;
        end
      end
      m_in_frame = !in_last;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic m,
                      input logic r);
    in_valid = v; in_data = d; in_last = l; mode = m; out_ready = r;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic m);
    int n = 0;
    do begin
      step(1'b1, d, l, m, 1'b1);
      n++;
    end while (!acc_flag && n < 50);
    if (!acc_flag) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_count", a_out_count, 0);
    check("rst_out_last", a_out_last, 0);
    check("rst_out_sat", a_out_sat, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_b_count", b_out_count, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w30 [4];
    int          c30 [4];
    logic [31:0] w32 [3];
    int          c32 [3];
    int          idx;
    int          n;
    bit          saw_block;
    logic [31:0] d;

    w30 = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 32'hA5A5_A5A5};
    c30 = '{0, 32, 2, 16};
    w32 = '{32'h0000_0003, 32'h0000_00FF, 32'h0000_FFFF};
    c32 = '{2, 8, 16};

    @(posedge clk);
    #1;
    do_reset();

    // Mode 0 back-to-back words, fixed latency.
    got_q.delete();
    chk_lat = 1;
    for (int i = 0; i < 4; i++) send(w30[i], 1'b1, 1'b0);
    idle(3);
    chk_lat = 0;
    check("m0_results", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++) check("m0_count", got_q[i].cnt_a, c30[i]);
    for (int i = 1; i < got_q.size(); i++) check("m0_consec", got_q[i].cyc - got_q[i-1].cyc, 1);

    // Mode 1 frame of three words.
    got_q.delete();
    send(32'hFFFF_FFFF, 1'b0, 1'b1);
    send(32'h0000_000F, 1'b0, 1'b1);
    send(32'h0000_0001, 1'b1, 1'b1);
    idle(3);
    check("m1_results", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("m1_count", got_q[0].cnt_a, 37);
      check("m1_last", got_q[0].last, 1);
      check("m1_sat", got_q[0].sat_a, 0);
    end

    // Saturation on the narrow accumulator, then a clean single-word frame.
    got_q.delete();
    send(32'hFFFF_FFFF, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 1'b1, 1'b1);
    send(32'h0000_0001, 1'b1, 1'b1);
    idle(3);
    check("sat_results", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("sat_cnt_b", got_q[0].cnt_b, 63);
      check("sat_flag_b", got_q[0].sat_b, 1);
      check("sat_cnt_a", got_q[0].cnt_a, 96);
      check("sat_flag_a", got_q[0].sat_a, 0);
      check("post_sat_cnt", got_q[1].cnt_b, 1);
      check("post_sat_flag", got_q[1].sat_b, 0);
    end

    // Backpressure: five cycles with out_ready low while three words are offered.
    got_q.delete();
    idx = 0;
    saw_block = 0;
    for (int i = 0; i < 5; i++) begin
      d = (idx < 3) ? w32[idx] : 32'h0;
      step(idx < 3, d, 1'b1, 1'b0, 1'b0);
      if (acc_flag) idx++;
      if (a_out_valid && !a_in_ready) saw_block = 1;
    end
    check("bp_blocked", saw_block, 1);
    n = 0;
    while (idx < 3 && n < 50) begin
      step(1'b1, w32[idx], 1'b1, 1'b0, 1'b1);
      if (acc_flag) idx++;
      n++;
    end
    idle(4);
    check("bp_results", got_q.size(), 3);
    for (int i = 0; i < got_q.size() && i < 3; i++) check("bp_order", got_q[i].cnt_a, c32[i]);

    // Mid-frame mode change is ignored; reset mid-frame discards everything in flight.
    got_q.delete();
    send(32'h0000_000F, 1'b0, 1'b1);
    send(32'h0000_00FF, 1'b0, 1'b0);
    send(32'h0000_0001, 1'b1, 1'b0);
    idle(3);
    check("mode_hold_results", got_q.size(), 1);
    if (got_q.size() > 0) check("mode_hold_count", got_q[0].cnt_a, 13);
    send(32'h0000_00FF, 1'b0, 1'b1);
    send(32'h0000_0007, 1'b1, 1'b1);
    do_reset();
    idle(3);
    check("rst_discard", got_q.size(), 1);
    send(32'hA5A5_A5A5, 1'b1, 1'b0);
    idle(3);
    check("post_rst_results", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("post_rst_count", got_q[1].cnt_a, 16);
      check("post_rst_last", got_q[1].last, 1);
    end

    // Random traffic with random backpressure, data mixes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 32'hFFFF_FFFF;
        1:       d = 32'h0;
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) != 0);
      end
    end
    idle(5);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
